// File: rtl/div_share_pkg.sv
// rtl/div_share_pkg.sv - shared types and constants for the divider-sharing arbiter
// Purpose : sequencer state encoding, default datapath width and the latency of
//           the shift-subtract divider this block fronts.
// Ports   : none (package).
package div_share_pkg;

  // Default operand/result width of the shared divider.
  localparam int DEFAULT_WIDTH = 32;

  // Cycles the shift-subtract divider needs from load to ready at DEFAULT_WIDTH.
  // The arbiter watchdog TIMEOUT must be set above this.
  localparam int DIV_LATENCY = 35;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RUN   = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/div_share_arbiter_if.sv
// rtl/div_share_arbiter_if.sv - requester-side request/response bus of the arbiter
// Purpose : bundles the per-requester request and response handshakes plus the
//           shared result bus.
// Signals : req_valid/req_ready/req_dividend/req_divisor  (request channel)
//           resp_valid/resp_ready/resp_quotient/resp_remainder/resp_err (response)
// Modports: master = requesters, slave = arbiter.
interface div_share_arbiter_if
  import div_share_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = DEFAULT_WIDTH
);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_dividend;
  logic [NUM_REQ*WIDTH-1:0] req_divisor;
  logic [NUM_REQ-1:0]       resp_valid;
  logic [NUM_REQ-1:0]       resp_ready;
  logic [WIDTH-1:0]         resp_quotient;
  logic [WIDTH-1:0]         resp_remainder;
  logic                     resp_err;

  modport master (
    output req_valid, req_dividend, req_divisor, resp_ready,
    input  req_ready, resp_valid, resp_quotient, resp_remainder, resp_err
  );

  modport slave (
    input  req_valid, req_dividend, req_divisor, resp_ready,
    output req_ready, resp_valid, resp_quotient, resp_remainder, resp_err
  );

endinterface

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin one-hot selector
// Purpose : picks the first asserted valid bit at or above ptr_i, wrapping from
//           NUM_REQ-1 back to 0.
// Ports   : valid_i     - request vector
//           ptr_i       - round-robin start position
//           grant_o     - one-hot grant (zero when nothing is valid)
//           grant_idx_o - index of the granted bit (0 when nothing is valid)
module rr_pick
  import div_share_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   grant_idx_o
);

  always_comb begin
    logic             found;
    int               idx;
    logic [IDX_W-1:0] sel;
    found       = 1'b0;
    idx         = 0;
    sel         = '0;
    grant_o     = '0;
    grant_idx_o = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_i) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      sel = IDX_W'(idx);
      if (!found && valid_i[sel]) begin
        found        = 1'b1;
        grant_o[sel] = 1'b1;
        grant_idx_o  = sel;
      end
    end
  end

endmodule

// File: rtl/div_share_arbiter.sv
// rtl/div_share_arbiter.sv - round-robin sharing of one multicycle divider
// Purpose : accepts one request at a time from NUM_REQ requesters, loads the
//           divider, waits for ready (with watchdog) and returns the result to
//           the owning requester over a valid/ready handshake.
// Ports   : clk, rst (async, active-high)
//           bus  - div_share_arbiter_if.slave requester request/response bus
//           busy - high outside IDLE
//           div_start/div_run/div_dividend/div_divisor - divider control/operands
//           div_rdy/div_quotient/div_remainder         - divider results
// Option  : DIV_ZERO_BYPASS_EN - zero divisors answered directly (q=all ones,
//           r=dividend) without starting the divider.
module div_share_arbiter
  import div_share_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  div_share_arbiter_if.slave  bus,
  output logic                busy,
  output logic                div_start,
  output logic                div_run,
  output logic [WIDTH-1:0]    div_dividend,
  output logic [WIDTH-1:0]    div_divisor,
  input  logic                div_rdy,
  input  logic [WIDTH-1:0]    div_quotient,
  input  logic [WIDTH-1:0]    div_remainder
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               err_q, err_d;

  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic [NUM_REQ-1:0] resp_valid_c;
  logic [WIDTH-1:0]   dvd_arr [NUM_REQ];
  logic [WIDTH-1:0]   dvs_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign dvd_arr[g] = bus.req_dividend[g*WIDTH +: WIDTH];
    assign dvs_arr[g] = bus.req_divisor[g*WIDTH +: WIDTH];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .valid_i     (bus.req_valid),
    .ptr_i       (rr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rr_q    <= '0;
      owner_q <= '0;
      wd_q    <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      wd_q    <= wd_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    wd_d    = wd_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        // Any grant bit implies req_valid & req_ready for that requester.
        if (|grant) begin
          owner_d = grant_idx;
          dvd_d   = dvd_arr[grant_idx];
          dvs_d   = dvs_arr[grant_idx];
          wd_d    = '0;
`ifdef DIV_ZERO_BYPASS_EN
          if (dvs_arr[grant_idx] == '0) begin
            quo_d   = '1;
            rem_d   = dvd_arr[grant_idx];
            err_d   = 1'b0;
            state_d = ST_RESP;
          end else begin
            state_d = ST_ISSUE;
          end
`else
          state_d = ST_ISSUE;
`endif
        end
      end
      ST_ISSUE: begin
        wd_d    = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        wd_d = wd_q + WD_W'(1);
        // div_rdy is checked first so it wins a tie with the watchdog.
        if (div_rdy) begin
          quo_d   = div_quotient;
          rem_d   = div_remainder;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          quo_d   = '0;
          rem_d   = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.resp_ready[owner_q]) begin
          rr_d    = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
          wd_d    = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    resp_valid_c = '0;
    if (state_q == ST_RESP) resp_valid_c[owner_q] = 1'b1;
  end

  assign bus.req_ready      = (state_q == ST_IDLE) ? grant : '0;
  assign bus.resp_valid     = resp_valid_c;
  assign bus.resp_quotient  = quo_q;
  assign bus.resp_remainder = rem_q;
  assign bus.resp_err       = err_q;

  assign busy         = (state_q != ST_IDLE);
  assign div_start    = (state_q == ST_ISSUE);
  assign div_run      = (state_q == ST_RUN);
  assign div_dividend = dvd_q;
  assign div_divisor  = dvs_q;

endmodule

// File: tb/tb_div_share_arbiter.sv
// tb/tb_div_share_arbiter.sv - self-checking bench for div_share_arbiter
module tb_div_share_arbiter;
  import div_share_pkg::*;

  localparam int N  = 2;
  localparam int W  = 32;
  localparam int TO = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_share_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus ();

  logic         busy, div_start, div_run, div_rdy;
  logic [W-1:0] div_dividend, div_divisor, div_quotient, div_remainder;

  div_share_arbiter #(.NUM_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .busy          (busy),
    .div_start     (div_start),
    .div_run       (div_run),
    .div_dividend  (div_dividend),
    .div_divisor   (div_divisor),
    .div_rdy       (div_rdy),
    .div_quotient  (div_quotient),
    .div_remainder (div_remainder)
  );

  // Divider model: ready after DIV_LATENCY counted run cycles; zero divisor
  // yields all-ones quotient and the dividend as remainder.
  logic         div_en;
  logic         m_act;
  int           m_cnt;
  logic [W-1:0] m_q, m_r;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_act <= 1'b0;
      m_cnt <= 0;
      m_q   <= '0;
      m_r   <= '0;
    end else if (div_start) begin
      m_act <= 1'b1;
      m_cnt <= 0;
      if (div_divisor == '0) begin
        m_q <= '1;
        m_r <= div_dividend;
      end else begin
        m_q <= div_dividend / div_divisor;
        m_r <= div_dividend % div_divisor;
      end
    end else if (div_run && m_act) begin
      if (div_rdy) m_act <= 1'b0;
      else         m_cnt <= m_cnt + 1;
    end
  end

  assign div_rdy       = div_en && m_act && div_run && (m_cnt == DIV_LATENCY);
  assign div_quotient  = m_q;
  assign div_remainder = m_r;

  typedef struct {
    int           id;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         err;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0, n_starts = 0, n_resp = 0;
  int last_acc_cyc = 0, last_start_cyc = 0, last_resp_cyc = 0;

  logic [N-1:0] snap_rv, snap_rr;
  logic [W-1:0] snap_q, snap_r;
  logic         snap_run;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.req_dividend[id*W +: W] = a;
    bus.req_divisor[id*W +: W]  = b;
    bus.req_valid[id]           = 1'b1;
  endtask

  task automatic push_exp(input int id, input logic [W-1:0] q, input logic [W-1:0] r,
                          input logic err);
    exp_t e;
    e.id = id; e.q = q; e.r = r; e.err = err;
    sb.push_back(e);
  endtask

  // One clock: sample at negedge, score response handshakes, then drop the
  // valid of any requester accepted on this edge.
  task automatic cycle();
    logic [N-1:0] acc, hs;
    exp_t e;
    @(negedge clk);
    cyc++;
    snap_rv  = bus.resp_valid;
    snap_rr  = bus.req_ready;
    snap_q   = bus.resp_quotient;
    snap_r   = bus.resp_remainder;
    snap_run = div_run;
    if (div_start) begin
      n_starts++;
      last_start_cyc = cyc;
    end
    acc = bus.req_valid & bus.req_ready;
    if (acc != '0) last_acc_cyc = cyc;
    hs = bus.resp_valid & bus.resp_ready;
    for (int i = 0; i < N; i++) begin
      if (hs[i]) begin
        n_resp++;
        last_resp_cyc = cyc;
        chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("resp_id", 64'(i), 64'(e.id));
          chk("resp_q", 64'(bus.resp_quotient), 64'(e.q));
          chk("resp_r", 64'(bus.resp_remainder), 64'(e.r));
          chk("resp_err", 64'(bus.resp_err), 64'(e.err));
        end
      end
    end
    @(posedge clk);
    #1;
    bus.req_valid = bus.req_valid & ~acc;
  endtask

  task automatic serve(input int n, input int budget);
    int start_cnt, t;
    start_cnt = n_resp;
    t = 0;
    while ((n_resp - start_cnt) < n && t < budget) begin
      cycle();
      t++;
    end
    chk("serve_done", 64'(n_resp - start_cnt), 64'(n));
  endtask

  task automatic do_reset();
    bus.req_valid = '0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int t, starts0;
    rst              = 1'b1;
    div_en           = 1'b1;
    bus.req_valid    = '0;
    bus.req_dividend = '0;
    bus.req_divisor  = '0;
    bus.resp_ready   = '1;
    do_reset();

    // Reset state
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst_div_start", 64'(div_start), 64'd0);
    chk("rst_div_run", 64'(div_run), 64'd0);
    chk("rst_resp_q", 64'(bus.resp_quotient), 64'd0);

    // Single request 100/7
    set_req(0, 100, 7);
    push_exp(0, 14, 2, 1'b0);
    starts0 = n_starts;
    serve(1, 200);
    chk("single_latency", 64'(last_resp_cyc - last_acc_cyc), 64'd38);
    chk("single_start_at", 64'(last_start_cyc - last_acc_cyc), 64'd1);
    chk("single_start_pulses", 64'(n_starts - starts0), 64'd1);

    // Contention after reset: req0 first, then req1, then pointer back to req0
    do_reset();
    set_req(0, 50, 5);
    set_req(1, 9, 4);
    push_exp(0, 10, 0, 1'b0);
    push_exp(1, 2, 1, 1'b0);
    serve(2, 300);
    set_req(0, 20, 3);
    set_req(1, 7, 7);
    push_exp(0, 6, 2, 1'b0);
    push_exp(1, 1, 0, 1'b0);
    serve(2, 300);

    // Backpressure: only req1's resp_ready high while req0 owns the divider
    bus.resp_ready = 2'b10;
    set_req(0, 1000, 10);
    set_req(1, 77, 8);
    push_exp(0, 100, 0, 1'b0);
    push_exp(1, 9, 5, 1'b0);
    t = 0;
    snap_rv = '0;
    while (snap_rv == '0 && t < 100) begin
      cycle();
      t++;
    end
    chk("bp_first_valid", 64'(snap_rv), 64'b01);
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("bp_hold_valid", 64'(snap_rv), 64'b01);
      chk("bp_hold_q", 64'(snap_q), 64'd100);
      chk("bp_hold_r", 64'(snap_r), 64'd0);
      chk("bp_no_req_ready", 64'(snap_rr), 64'd0);
    end
    chk("bp_req1_pending", 64'(bus.req_valid[1]), 64'd1);
    bus.resp_ready = 2'b11;
    serve(2, 300);

    // Watchdog timeout with divider never ready
    div_en = 1'b0;
    set_req(0, 5, 1);
    push_exp(0, 0, 0, 1'b1);
    serve(1, 200);
    chk("timeout_latency", 64'(last_resp_cyc - last_acc_cyc), 64'(2 + TO));
    div_en = 1'b1;

    // Divide by zero 123/0
    starts0 = n_starts;
    set_req(1, 123, 0);
    push_exp(1, 32'hFFFF_FFFF, 123, 1'b0);
    serve(1, 200);
`ifdef DIV_ZERO_BYPASS_EN
    chk("dz_latency", 64'(last_resp_cyc - last_acc_cyc), 64'd1);
    chk("dz_no_start", 64'(n_starts - starts0), 64'd0);
`else
    chk("dz_latency", 64'(last_resp_cyc - last_acc_cyc), 64'd38);
    chk("dz_start", 64'(n_starts - starts0), 64'd1);
`endif

    // Reset during RUN, then a fresh request completes
    set_req(0, 100, 7);
    for (int k = 0; k < 4; k++) cycle();
    chk("pre_rst_in_run", 64'(snap_run), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_div_run", 64'(div_run), 64'd0);
    chk("arst_div_start", 64'(div_start), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_resp_valid", 64'(bus.resp_valid), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    set_req(0, 100, 7);
    push_exp(0, 14, 2, 1'b0);
    serve(1, 200);
    chk("post_rst_latency", 64'(last_resp_cyc - last_acc_cyc), 64'd38);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
